// File: rtl/sasa_tile_sched.sv
// sasa_tile_sched: walks a MAT_DIM x MAT_DIM QK score matrix in BLK x BLK tiles.
// Each tile gets one eng_start pulse carrying its pivot, then the scheduler waits
// for eng_finish under a per-tile watchdog. Full and causal (x<=y) traversal.
module sasa_tile_sched #(
   parameter int MAT_DIM = 16,
   parameter int BLK     = 4,
   parameter int TIMEOUT = 256,
   localparam int NT = MAT_DIM / BLK,
   localparam int TW = $clog2(MAT_DIM),
   localparam int CW = $clog2(NT * NT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          causal,
   input  logic          abort,
   output logic          eng_start,
   output logic [TW-1:0] eng_tile_x,
   output logic [TW-1:0] eng_tile_y,
   input  logic          eng_finish,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] tiles_done,
   output logic          timeout_err
);

   localparam int TMW = $clog2(TIMEOUT);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_NEXT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   localparam logic [TW-1:0]  LAST    = TW'(MAT_DIM - BLK);
   localparam logic [TW-1:0]  STEP    = TW'(BLK);
   localparam logic [TMW-1:0] T_MAX   = TMW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(NT * NT);

   logic [2:0]     state, state_nxt;
   logic [TW-1:0]  tile_x, tile_y;
   logic [TMW-1:0] timer;
   logic           causal_q;
   logic           last_tile, row_end, timed_out;

   // The last tile is the bottom-right corner in both modes; a row ends at the
   // diagonal in causal mode and at the right edge otherwise.
   assign last_tile = (tile_x == LAST) && (tile_y == LAST);
   assign row_end   = causal_q ? (tile_x == tile_y) : (tile_x == LAST);
   assign timed_out = (timer == T_MAX);

   // Outputs decoded from the state register or taken straight from registers.
   assign eng_start  = (state == S_ISSUE);
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign eng_tile_x = tile_x;
   assign eng_tile_y = tile_y;

   // Next-state decode; abort beats finish and timeout in every busy state.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = abort ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (abort)           state_nxt = S_IDLE;
            else if (eng_finish) state_nxt = S_NEXT;
            else if (timed_out)  state_nxt = S_ERR;
         end
         S_NEXT:  state_nxt = abort ? S_IDLE : (last_tile ? S_DONE : S_ISSUE);
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Tile pointer and causal latch: cleared on accepted start, advanced in NEXT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tile_x   <= '0;
         tile_y   <= '0;
         causal_q <= 1'b0;
      end else if (state == S_IDLE && start) begin
         tile_x   <= '0;
         tile_y   <= '0;
         causal_q <= causal;
      end else if (state == S_NEXT && !abort && !last_tile) begin
         if (row_end) begin
            tile_x <= '0;
            tile_y <= tile_y + STEP;
         end else begin
            tile_x <= tile_x + STEP;
         end
      end
   end

   // Watchdog timer: zeroed in ISSUE, counts WAIT cycles, stops at its limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer <= '0;
      end else if (state == S_ISSUE) begin
         timer <= '0;
      end else if (state == S_WAIT && !abort && !eng_finish && !timed_out) begin
         timer <= timer + TMW'(1);
      end
   end

   // Completed-tile counter and sticky watchdog error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tiles_done  <= '0;
         timeout_err <= 1'b0;
      end else if (state == S_IDLE && start) begin
         tiles_done  <= '0;
         timeout_err <= 1'b0;
      end else if (state == S_WAIT && !abort) begin
         if (eng_finish) begin
            if (tiles_done != CNT_MAX) tiles_done <= tiles_done + CW'(1);
         end else if (timed_out) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sasa_tile_sched.sv
// tb_sasa_tile_sched: table of whole-pass vectors driven by a small engine
// responder, plus a hand-written async-reset sequence embedded in the table.
module tb_sasa_tile_sched;

   localparam int MAT_DIM = 16;
   localparam int BLK     = 4;
   localparam int TIMEOUT = 256;
   localparam int NT      = MAT_DIM / BLK;
   localparam int BUDGET  = 4000;

   logic       clk = 1'b0;
   logic       reset, start, causal, abort, eng_finish;
   logic       eng_start, busy, done, timeout_err;
   logic [3:0] eng_tile_x, eng_tile_y;
   logic [4:0] tiles_done;

   int checks   = 0;
   int failures = 0;

   sasa_tile_sched #(.MAT_DIM(MAT_DIM), .BLK(BLK), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .causal(causal), .abort(abort),
      .eng_start(eng_start), .eng_tile_x(eng_tile_x), .eng_tile_y(eng_tile_y),
      .eng_finish(eng_finish), .busy(busy), .done(done),
      .tiles_done(tiles_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      logic  causal;
      int    delay;        // finish on this WAIT cycle (1 = first WAIT cycle)
      int    withhold;     // tile index whose finish is never given (-1 none)
      int    abort_tile;   // tile index aborted on its 2nd WAIT cycle (-1 none)
      int    reset_tile;   // tile index reset on its 2nd WAIT cycle (-1 none)
      bit    stale;        // keep finish high through NEXT and ISSUE
      bit    start_noise;  // pulse start while busy
      bit    abort_w_start;// abort asserted together with the accepted start
      int    exp_pulses;
      int    exp_dones;
      int    exp_tiles;
      int    exp_err;
   } pass_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_pass(input pass_vec_t v);
      int exp_x[$];
      int exp_y[$];
      int pulses = 0, dones = 0, cnt = 0, cyc = 0, cur;
      bit ended = 0, err_seen = 0, abort_sent = 0, reset_hit = 0;
      for (int y = 0; y < NT; y++) begin
         for (int x = 0; x < NT; x++) begin
            if (!v.causal || x <= y) begin
               exp_x.push_back(x * BLK);
               exp_y.push_back(y * BLK);
            end
         end
      end
      causal = v.causal;
      start  = 1'b1;
      abort  = v.abort_w_start;
      step();
      start  = 1'b0;
      abort  = 1'b0;
      causal = 1'b0;
      while (cyc < BUDGET) begin
         if (abort_sent) check({v.name, "_abort_to_idle"}, busy, 0);
         if (!busy) begin
            ended = 1;
            break;
         end
         if (eng_start) begin
            if (pulses == 0) begin
               check({v.name, "_start_tiles_cleared"}, tiles_done, 0);
               check({v.name, "_start_err_cleared"}, timeout_err, 0);
            end
            if (pulses < exp_x.size()) begin
               check($sformatf("%s_tile%0d_x", v.name, pulses), eng_tile_x, exp_x[pulses]);
               check($sformatf("%s_tile%0d_y", v.name, pulses), eng_tile_y, exp_y[pulses]);
            end
            pulses++;
            cnt = 0;
         end else begin
            cnt++;
         end
         if (done) dones++;
         if (timeout_err && !err_seen) begin
            err_seen = 1;
            check({v.name, "_err_after_timeout_cycles"}, cnt, TIMEOUT + 1);
            check({v.name, "_err_state_busy"}, busy, 1);
         end
         cur = pulses - 1;
         if (v.reset_tile == cur && cnt == 2) begin
            reset = 1'b1;
            #1;
            check({v.name, "_rst_busy"}, busy, 0);
            check({v.name, "_rst_eng_start"}, eng_start, 0);
            check({v.name, "_rst_done"}, done, 0);
            check({v.name, "_rst_x"}, eng_tile_x, 0);
            check({v.name, "_rst_y"}, eng_tile_y, 0);
            check({v.name, "_rst_tiles_done"}, tiles_done, 0);
            check({v.name, "_rst_err"}, timeout_err, 0);
            eng_finish = 1'b0;
            step();
            reset = 1'b0;
            reset_hit = 1;
            break;
         end
         // Engine response for the current cycle.
         if (cur == v.withhold)  eng_finish = 1'b0;
         else if (v.stale)       eng_finish = eng_start || (cnt >= v.delay);
         else                    eng_finish = !eng_start && (cnt == v.delay);
         abort = (v.abort_tile == cur) && (cnt == 2) && !eng_start;
         if (abort) abort_sent = 1;
         start = v.start_noise && (cnt == 2) && !eng_start;
         step();
         start = 1'b0;
         abort = 1'b0;
         cyc++;
      end
      eng_finish = 1'b0;
      abort      = 1'b0;
      start      = 1'b0;
      if (!reset_hit) begin
         check({v.name, "_pass_ended_in_budget"}, ended, 1);
         check({v.name, "_pulses"}, pulses, v.exp_pulses);
         check({v.name, "_dones"}, dones, v.exp_dones);
         check({v.name, "_tiles_done"}, tiles_done, v.exp_tiles);
         check({v.name, "_timeout_err"}, timeout_err, v.exp_err);
      end
      step();
   endtask

   pass_vec_t vecs[9];

   initial begin
      //          name          causal dly  wh  ab  rs stale noise aws  pul dn til err
      vecs[0] = '{"T1_full",     1'b0,   5, -1, -1, -1, 0, 0, 1,   16, 1, 16, 0};
      vecs[1] = '{"T2_causal",   1'b1,   5, -1, -1, -1, 0, 0, 0,   10, 1, 10, 0};
      vecs[2] = '{"T3_watchdog", 1'b0,   5,  2, -1, -1, 0, 0, 0,    3, 0,  2, 1};
      vecs[3] = '{"T4_abort",    1'b0,   2, -1,  4, -1, 0, 0, 0,    5, 0,  4, 0};
      vecs[4] = '{"T4_restart",  1'b0,   3, -1, -1, -1, 0, 0, 0,   16, 1, 16, 0};
      vecs[5] = '{"T5_race",     1'b1, 256, -1, -1, -1, 1, 1, 0,   10, 1, 10, 0};
      vecs[6] = '{"fast_causal", 1'b1,   1, -1, -1, -1, 0, 0, 0,   10, 1, 10, 0};
      vecs[7] = '{"T6_reset",    1'b0,   5, -1, -1,  1, 0, 0, 0,    0, 0,  0, 0};
      vecs[8] = '{"T6_after",    1'b0,   5, -1, -1, -1, 0, 0, 0,   16, 1, 16, 0};

      reset = 1'b1;
      start = 1'b0;
      causal = 1'b0;
      abort = 1'b0;
      eng_finish = 1'b0;
      step();
      step();
      check("reset_busy", busy, 0);
      check("reset_eng_start", eng_start, 0);
      check("reset_done", done, 0);
      check("reset_x", eng_tile_x, 0);
      check("reset_y", eng_tile_y, 0);
      check("reset_tiles_done", tiles_done, 0);
      check("reset_err", timeout_err, 0);
      reset = 1'b0;
      step();

      // abort alone in IDLE does nothing
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_eng_start", eng_start, 0);

      for (int i = 0; i < 9; i++) run_pass(vecs[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
